// File: rtl/encoder.sv
// Registered 32-to-5 index encoder: latches a multi-hot request vector and
// streams out the index of every set bit, lowest first, one per handshake.
module encoder #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] A,
    output logic          out_last,
    output logic          zero_err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]    state;
    logic [N-1:0]  pend;

    logic [N-1:0]  pend_clr;
    logic [AW-1:0] in_index;
    logic [AW-1:0] clr_index;
    logic          in_single;
    logic          clr_single;
    logic          in_nonzero;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    // Bit k maps to (k+1) mod N so the output matches the decoder's numbering.
    function automatic logic [AW-1:0] encode_index(input logic [N-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = AW'(k + 1);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pend_clr   = '0;
        in_index   = '0;
        clr_index  = '0;
        in_single  = 1'b0;
        clr_single = 1'b0;
        in_nonzero = 1'b0;

        pend_clr   = pend & ~lowest_bit(pend);
        in_index   = encode_index(in_vec);
        clr_index  = encode_index(pend_clr);
        in_single  = is_single(in_vec);
        clr_single = is_single(pend_clr);
        in_nonzero = (in_vec != '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            A         <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            zero_err  <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_nonzero) begin
                            pend      <= in_vec;
                            A         <= in_index;
                            out_last  <= in_single;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            zero_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        pend <= pend_clr;
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Next index comes from the post-clear vector so A stays a flop.
                            A        <= clr_index;
                            out_last <= clr_single;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: a reference model pushes expected indices
// into a scoreboard, and a monitor pops and compares on each output handshake.
module tb_encoder;

    localparam int N  = 32;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] a;
        logic          last;
        logic [N-1:0]  vec;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] A;
    logic          out_last;
    logic          zero_err;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    encoder #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: A maps back to bit (A-1) mod N.
    function automatic logic [N-1:0] decode(input logic [AW-1:0] a);
        logic [AW-1:0] k;
        k = a - AW'(1);
        return N'(1) << k;
    endfunction

    task automatic push_model(input logic [N-1:0] vec);
        exp_t e;
        logic [N-1:0] above;
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                above  = (k == N - 1) ? '0 : (vec >> (k + 1));
                e.a    = AW'((k + 1) % N);
                e.last = (above == '0);
                e.vec  = N'(1) << k;
                sb.push_back(e);
            end
        end
    endtask

    // Output monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("A", 32'(A), 32'(e.a));
                check("out_last", 32'(out_last), 32'(e.last));
                check("loopback", decode(A), e.vec);
            end
        end
    end

    task automatic send(input logic [N-1:0] vec, input bit model);
        int budget;
        budget = 200;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("send_in_ready", 32'(in_ready), 1);
        in_vec   = vec;
        in_valid = 1'b1;
        if (model) push_model(vec);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 200;
        while ((sb.size() != 0 || !in_ready) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_sb_empty", sb.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;

        // Reset held for 4 cycles
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_A", 32'(A), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_zero_err", 32'(zero_err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Single-bit sweep
        out_ready = 1'b1;
        for (int i = 1; i <= N; i++) begin
            send(N'(1) << (i - 1), 1'b1);
            check("sweep_valid", 32'(out_valid), 1);
            check("sweep_A", 32'(A), 32'(i % N));
            check("sweep_last", 32'(out_last), 1);
            wait_idle();
        end

        // Multi-bit drain: indices 1, 3, 0
        send(32'h8000_0005, 1'b1);
        check("multi_first_A", 32'(A), 1);
        @(posedge clk); #1;
        check("multi_busy", 32'(in_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("multi_turn_ready", 32'(in_ready), 1);
        check("multi_turn_valid", 32'(out_valid), 0);
        wait_idle();

        // Backpressure with an ignored in_valid pulse during the stall
        out_ready = 1'b0;
        send(32'h0000_0006, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_A", 32'(A), 2);
            check("stall_last", 32'(out_last), 0);
            if (c == 1) begin
                in_vec   = 32'h0000_FFFF;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_A", 32'(A), 3);
        check("bp_next_last", 32'(out_last), 1);
        @(posedge clk); #1;
        check("bp_done_valid", 32'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_accept", 32'(out_valid), 0);
        wait_idle();

        // Zero vector
        send('0, 1'b0);
        check("zero_err_pulse", 32'(zero_err), 1);
        check("zero_in_ready", 32'(in_ready), 1);
        check("zero_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("zero_err_clear", 32'(zero_err), 0);
        check("zero_valid2", 32'(out_valid), 0);
        check("zero_in_ready2", 32'(in_ready), 1);

        // Reset mid-drain, with a colliding in_valid that reset must win over
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_A4", 32'(A), 4);
        out_ready = 1'b0;
        reset     = 1'b1;
        in_vec    = 32'h0000_0010;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_A", 32'(A), 0);
        @(posedge clk); #1;
        check("mid_rst_no_accept", 32'(out_valid), 0);
        out_ready = 1'b1;
        send(32'h0000_0010, 1'b1);
        check("post_rst_A", 32'(A), 5);
        check("post_rst_last", 32'(out_last), 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
